// File: rtl/guess_game_pkg.sv
// Shared types and helpers for the number-guessing controller.
package guess_game_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_WAIT,
        S_WIN,
        S_LOSE
    } gg_state_t;

    // Width needed to hold a tries count from 0 up to and including max_tries.
    function automatic int TRY_W(input int max_tries);
        return $clog2(max_tries + 1);
    endfunction

endpackage

// File: rtl/guess_game_ctrl_btn_press.sv
// Enter-button conditioning: 2-FF synchroniser, optional debounce filter,
// rising-edge detect. Optional filter is enabled by GUESS_DEBOUNCE_EN.
module btn_press
    import guess_game_pkg::*;
#(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic enter,
    output logic press
);

    logic sync_1;
    logic sync_2;
    logic level;
    logic prev;

    // Bring the raw button into the clk domain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= enter;
            sync_2 <= sync_1;
        end
    end

`ifdef GUESS_DEBOUNCE_EN
    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] DB_LOAD = CW'(DB_CYCLES - 1);

    logic [CW-1:0] db_cnt;
    logic          db_level;

    // Down-counter restarts whenever sync agrees with the filtered level;
    // the level flips only after DB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_cnt   <= DB_LOAD;
            db_level <= 1'b0;
        end else if (sync_2 == db_level) begin
            db_cnt <= DB_LOAD;
        end else if (db_cnt == '0) begin
            db_level <= sync_2;
            db_cnt   <= DB_LOAD;
        end else begin
            db_cnt <= db_cnt - 1'b1;
        end
    end

    assign level = db_level;
`else
    assign level = sync_2;
`endif

    // Previous level for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev <= 1'b0;
        end else begin
            prev <= level;
        end
    end

    assign press = level & ~prev;

endmodule

// File: rtl/guess_game_ctrl.sv
// Number-guessing controller: free-running secret counter, up to MAX_TRIES
// guesses per game, win/lose reporting, new game on press without reset.
// Optional enter-button debounce filter enabled by GUESS_DEBOUNCE_EN.
//
//  state   | meaning
//  S_IDLE  | secret counts freely, waiting for first press
//  S_CHECK | one cycle: compare guess, bump tries, pick outcome
//  S_WAIT  | LEDs hold, waiting for next guess press
//  S_WIN   | guess matched; press starts a new game
//  S_LOSE  | tries exhausted, secret shown; press starts a new game
module guess_game_ctrl
    import guess_game_pkg::*;
#(
    parameter int W         = 8,
    parameter int MAX_TRIES = 4,
    parameter int DB_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_enter,
    input  logic [W-1:0]                  i_guess,
    output logic                          o_over,
    output logic                          o_under,
    output logic                          o_equal,
    output logic                          o_win,
    output logic                          o_lose,
    output logic [TRY_W(MAX_TRIES)-1:0]   o_tries_used,
    output logic [W-1:0]                  o_secret
);

    localparam int TW = TRY_W(MAX_TRIES);
    localparam logic [TW-1:0] MAX_T = TW'(MAX_TRIES);

    gg_state_t      state, state_nxt;
    logic [W-1:0]   secret, secret_nxt;
    logic           over_nxt, under_nxt, equal_nxt, win_nxt, lose_nxt;
    logic [TW-1:0]  tries_nxt;
    logic [TW-1:0]  tries_inc;
    logic [W-1:0]   secret_out_nxt;
    logic           press;

    btn_press #(
        .DB_CYCLES (DB_CYCLES)
    ) u_btn_press (
        .clk   (clk),
        .reset (reset),
        .enter (i_enter),
        .press (press)
    );

    assign tries_inc = o_tries_used + TW'(1);

    // State, secret and all output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            secret       <= '0;
            o_over       <= 1'b0;
            o_under      <= 1'b0;
            o_equal      <= 1'b0;
            o_win        <= 1'b0;
            o_lose       <= 1'b0;
            o_tries_used <= '0;
            o_secret     <= '0;
        end else begin
            state        <= state_nxt;
            secret       <= secret_nxt;
            o_over       <= over_nxt;
            o_under      <= under_nxt;
            o_equal      <= equal_nxt;
            o_win        <= win_nxt;
            o_lose       <= lose_nxt;
            o_tries_used <= tries_nxt;
            o_secret     <= secret_out_nxt;
        end
    end

    // Next-state and next-output logic; everything holds unless a state acts.
    always_comb begin
        state_nxt      = state;
        secret_nxt     = secret;
        over_nxt       = o_over;
        under_nxt      = o_under;
        equal_nxt      = o_equal;
        win_nxt        = o_win;
        lose_nxt       = o_lose;
        tries_nxt      = o_tries_used;
        secret_out_nxt = o_secret;

        case (state)
            S_IDLE: begin
                if (press) begin
                    state_nxt = S_CHECK;
                    tries_nxt = '0;
                end else begin
                    secret_nxt = secret + W'(1);
                end
            end
            S_CHECK: begin
                over_nxt  = (i_guess > secret);
                under_nxt = (i_guess < secret);
                equal_nxt = (i_guess == secret);
                tries_nxt = tries_inc;
                if (i_guess == secret) begin
                    state_nxt = S_WIN;
                    win_nxt   = 1'b1;
                end else if (tries_inc == MAX_T) begin
                    state_nxt      = S_LOSE;
                    lose_nxt       = 1'b1;
                    secret_out_nxt = secret;
                end else begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (press) begin
                    state_nxt = S_CHECK;
                end
            end
            S_WIN, S_LOSE: begin
                if (press) begin
                    state_nxt      = S_IDLE;
                    over_nxt       = 1'b0;
                    under_nxt      = 1'b0;
                    equal_nxt      = 1'b0;
                    win_nxt        = 1'b0;
                    lose_nxt       = 1'b0;
                    tries_nxt      = '0;
                    secret_out_nxt = '0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Self-checking bench for guess_game_ctrl (W=8, MAX_TRIES=4).
module tb_guess_game_ctrl;

    localparam int W  = 8;
    localparam int MT = 4;
    localparam int TW = 3;
`ifdef GUESS_DEBOUNCE_EN
    localparam int LAT = 3 + 16;
`else
    localparam int LAT = 3;
`endif
    localparam int REL = LAT + 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          i_enter = 1'b0;
    logic [W-1:0]  i_guess = '0;
    logic          o_over, o_under, o_equal, o_win, o_lose;
    logic [TW-1:0] o_tries_used;
    logic [W-1:0]  o_secret;

    guess_game_ctrl #(
        .W         (W),
        .MAX_TRIES (MT),
        .DB_CYCLES (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_enter      (i_enter),
        .i_guess      (i_guess),
        .o_over       (o_over),
        .o_under      (o_under),
        .o_equal      (o_equal),
        .o_win        (o_win),
        .o_lose       (o_lose),
        .o_tries_used (o_tries_used),
        .o_secret     (o_secret)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [15:0] exp;
    } sb_item_t;

    sb_item_t   sb_q[$];
    int         n_chk  = 0;
    int         n_pass = 0;
    logic [7:0] secret_m;
    int         tries_m;

    // {over, under, equal, win, lose, tries[2:0], secret[7:0]}
    function automatic logic [15:0] obs();
        return {o_over, o_under, o_equal, o_win, o_lose, o_tries_used, o_secret};
    endfunction

    function automatic logic [15:0] model(input logic [7:0] g, input logic [7:0] s, input int t_after);
        logic eq;
        logic ls;
        eq = (g == s);
        ls = !eq && (t_after == MT);
        return {g > s, g < s, eq, eq, ls, 3'(t_after), ls ? s : 8'h00};
    endfunction

    task automatic check_val(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    // Reset (checked asynchronously), release, idle n cycles before next press.
    task automatic start_game(input int n);
        @(negedge clk);
        reset = 1'b0;
        i_enter = 1'b0;
        #1;
        check_val("reset", obs(), 16'h0000);
        @(negedge clk);
        reset = 1'b1;
        repeat (n) @(negedge clk);
        secret_m = 8'((n + LAT - 1) % 256);
        tries_m  = 0;
    endtask

    // Press with a guess on the switches; expectation queued at drive time.
    task automatic press_chk(input string tag, input logic [7:0] g, input logic [15:0] exp, input int hold);
        sb_item_t it;
        i_guess = g;
        i_enter = 1'b1;
        sb_q.push_back('{tag, exp});
        repeat (LAT + 1) @(posedge clk);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            check_val({tag, "_sb_empty"}, 16'hffff, 16'h0000);
        end else begin
            it = sb_q.pop_front();
            check_val(it.tag, obs(), it.exp);
            if (hold > LAT + 1) begin
                repeat (hold - LAT - 1) @(negedge clk);
                check_val({it.tag, "_hold"}, obs(), it.exp);
            end
        end
        i_enter = 1'b0;
        repeat (REL) @(negedge clk);
    endtask

    task automatic guess(input string tag, input logic [7:0] g, input int hold);
        tries_m++;
        press_chk(tag, g, model(g, secret_m, tries_m), hold);
    endtask

    initial begin
        // Long idle forces the secret through its 255 -> 0 wrap.
        start_game(300);
        check_val("idle_secret0", obs(), 16'h0000);
        guess("a_over",  secret_m + 8'd1, 0);
        guess("a_under", secret_m - 8'd1, 0);
        guess("a_over2", secret_m + 8'd2, 0);
        guess("a_lose",  secret_m - 8'd2, 0);
        repeat (10) @(negedge clk);
        check_val("a_lose_held", obs(), {5'b01001, 3'd4, secret_m});
        press_chk("a_newgame", 8'h00, 16'h0000, 0);
        repeat (20) @(negedge clk);
        check_val("a_idle_after", obs(), 16'h0000);

        // Reset in the middle of S_WAIT.
        start_game(10);
        guess("b_over", secret_m + 8'd3, 0);

        // Win on the last allowed try; extreme guess values.
        start_game(5);
        guess("c_under0", 8'h00, 0);
        guess("c_over255", 8'hff, 0);
        guess("c_over1", secret_m + 8'd1, 0);
        guess("c_win_last", secret_m, 0);
        press_chk("c_newgame_held", 8'h00, 16'h0000, 50);

        // Button held long gives exactly one check.
        start_game(20);
        guess("d_held", secret_m + 8'd8, 50);
`ifdef GUESS_DEBOUNCE_EN
        i_guess = secret_m;
        i_enter = 1'b1;
        repeat (10) @(negedge clk);
        i_enter = 1'b0;
        repeat (30) @(negedge clk);
        check_val("d_glitch", obs(), model(secret_m + 8'd8, secret_m, 1));
`endif
        guess("d_win", secret_m, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
